// File: rtl/intr_pkg.sv
// -----------------------------------------------------------------------------
// intr_pkg
//   Shared definitions for the priority interrupt controller: FSM state
//   encoding, bus register offsets and a helper that builds the mask of
//   implemented source bits.
// -----------------------------------------------------------------------------
package intr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } intr_state_e;

    localparam logic [31:0] OFF_PEND = 32'h0000_0000;
    localparam logic [31:0] OFF_MASK = 32'h0000_0004;
    localparam logic [31:0] OFF_ID   = 32'h0000_0008;
    localparam logic [31:0] OFF_EOI  = 32'h0000_000C;

    // One bit set for every implemented source; bits at or above n stay 0.
    function automatic logic [31:0] src_mask(input int unsigned n);
        logic [31:0] m;
        m = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < n) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/prio_enc32.sv
// -----------------------------------------------------------------------------
// prio_enc32
//   Combinational 32-bit priority encoder, lowest set index wins.
//
//   vec_i   : request vector
//   idx_o   : index of the lowest set bit (0 when nothing is set)
//   valid_o : at least one bit of vec_i is set
// -----------------------------------------------------------------------------
module prio_enc32 (
    input  logic [31:0] vec_i,
    output logic [4:0]  idx_o,
    output logic        valid_o
);

    // Scanning from the top down lets the lowest set bit be the last writer.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o   = 5'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/intr_ctrl.sv
// -----------------------------------------------------------------------------
// intr_ctrl
//   Memory-mapped priority interrupt controller in front of the CPU. Captures
//   rising edges on up to N_SRC interrupt lines, selects the lowest-numbered
//   enabled pending source, requests the CPU via intr and tracks a single
//   in-service source until an end-of-interrupt write.
//
//   clk    : system clock
//   clrn   : asynchronous active-low reset
//   irq    : source lines, rising-edge triggered
//   intr   : registered interrupt request to the CPU
//   inta   : CPU acknowledge pulse
//   addr   : bus address
//   wdata  : bus write data
//   we     : bus write enable
//   rdata  : combinational read data, 0 for undecoded addresses
//   irq_id : in-service source ID
//
//   Register map (offsets from BASE):
//     0x0 PEND  read pending, write-1-to-clear
//     0x4 MASK  read/write enable bits
//     0x8 ID    {26'b0, busy, irq_id}
//     0xC EOI   any write ends service, reads 0
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | nothing requested; waits for an enabled pending source
//   REQ     | intr high for sel_id, waiting for inta
//   SERVICE | sel_id acknowledged and in service, waiting for EOI write
// -----------------------------------------------------------------------------
module intr_ctrl
    import intr_pkg::*;
#(
    parameter int unsigned N_SRC = 8,
    parameter logic [31:0] BASE  = 32'hFFFF_FF00
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [N_SRC-1:0] irq,
    output logic             intr,
    input  logic             inta,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    input  logic             we,
    output logic [31:0]      rdata,
    output logic [4:0]       irq_id
);

    localparam logic [31:0] SRC_MASK  = src_mask(N_SRC);
    localparam logic [31:0] ADDR_PEND = BASE + OFF_PEND;
    localparam logic [31:0] ADDR_MASK = BASE + OFF_MASK;
    localparam logic [31:0] ADDR_ID   = BASE + OFF_ID;
    localparam logic [31:0] ADDR_EOI  = BASE + OFF_EOI;

    logic [N_SRC-1:0] irq_dly_q;
    logic [31:0]      pend_q, pend_d;
    logic [31:0]      mask_q, mask_d;
    intr_state_e      state_q;
    logic [4:0]       sel_id_q;
    logic [4:0]       irq_id_q;
    logic             busy_q;
    logic             intr_q;

    logic [31:0]      edge_vec;
    logic [31:0]      cand;
    logic [4:0]       cand_idx;
    logic             cand_valid;
    logic             hit_pend, hit_mask, hit_id, hit_eoi;
    logic             wr_pend, wr_mask, eoi;
    logic             ack;

    // ---------------- bus decode ----------------
    assign hit_pend = (addr == ADDR_PEND);
    assign hit_mask = (addr == ADDR_MASK);
    assign hit_id   = (addr == ADDR_ID);
    assign hit_eoi  = (addr == ADDR_EOI);

    assign wr_pend  = we & hit_pend;
    assign wr_mask  = we & hit_mask;
    assign eoi      = we & hit_eoi;

    always_comb begin
        rdata = '0;
        if (hit_pend) begin
            rdata = pend_q;
        end else if (hit_mask) begin
            rdata = mask_q;
        end else if (hit_id) begin
            rdata = {26'b0, busy_q, irq_id_q};
        end
    end

    // ---------------- edge capture and pending ----------------
    assign edge_vec = 32'(irq & ~irq_dly_q);
    assign cand     = pend_q & mask_q;
    assign ack      = (state_q == ST_REQ) & inta;

    prio_enc32 u_prio_enc32 (
        .vec_i   (cand),
        .idx_o   (cand_idx),
        .valid_o (cand_valid)
    );

    // Order matters: W1C first, then a fresh edge re-sets the bit, and an
    // acknowledge clears the accepted source over both.
    always_comb begin
        pend_d = pend_q;
        if (wr_pend) begin
            pend_d = pend_d & ~wdata;
        end
        pend_d = pend_d | edge_vec;
        if (ack) begin
            pend_d[sel_id_q] = 1'b0;
        end
        pend_d = pend_d & SRC_MASK;
    end

    assign mask_d = wr_mask ? (wdata & SRC_MASK) : mask_q;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            irq_dly_q <= '0;
            pend_q    <= '0;
            mask_q    <= '0;
        end else begin
            irq_dly_q <= irq;
            pend_q    <= pend_d;
            mask_q    <= mask_d;
        end
    end

    // ---------------- request / service FSM ----------------
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q  <= ST_IDLE;
            sel_id_q <= '0;
            irq_id_q <= '0;
            busy_q   <= 1'b0;
            intr_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cand_valid) begin
                        state_q  <= ST_REQ;
                        sel_id_q <= cand_idx;
                        intr_q   <= 1'b1;
                    end
                end
                ST_REQ: begin
                    // sel_id is held; a higher-priority arrival waits its turn.
                    if (inta) begin
                        state_q  <= ST_SERVICE;
                        irq_id_q <= sel_id_q;
                        busy_q   <= 1'b1;
                        intr_q   <= 1'b0;
                    end else if (!cand[sel_id_q]) begin
                        state_q <= ST_IDLE;
                        intr_q  <= 1'b0;
                    end
                end
                ST_SERVICE: begin
                    if (eoi) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    intr_q  <= 1'b0;
                end
            endcase
        end
    end

    assign intr   = intr_q;
    assign irq_id = irq_id_q;

endmodule
